rv_dm_arbiter: RTL

//  Shares the single data-memory port between two masters: the execute stage

---
 rtl/rv_dm_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/rv_dm_arbiter.sv
// rv_dm_arbiter: shares one data-memory port between the execute-stage
// load/store port (CPU) and a secondary master (EXT). Round-robin per
// transaction, grant locked across ready stalls, one outstanding load with
// completion routed to its owner, and a timeout for loads that never finish.

module rv_dm_arbiter #(
    parameter int LOAD_TIMEOUT = 256,
    parameter int CNT_W        = 9
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_s_i,
    input  logic [3:0]  cpu_data_select_i,
    input  logic        cpu_load_i,
    input  logic        cpu_store_i,
    output logic        cpu_ready_o,
    output logic [31:0] cpu_data_l_o,
    output logic        cpu_load_done_o,
    input  logic [31:0] ext_addr_i,
    input  logic [31:0] ext_data_s_i,
    input  logic [3:0]  ext_data_select_i,
    input  logic        ext_load_i,
    input  logic        ext_store_i,
    output logic        ext_ready_o,
    output logic [31:0] ext_data_l_o,
    output logic        ext_load_done_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_data_s_o,
    output logic [3:0]  dm_data_select_o,
    output logic        dm_load_o,
    output logic        dm_store_o,
    input  logic        dm_ready_i,
    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,
    output logic        err_timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_WAIT = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_r;
    logic             owner_r;   // 0 = CPU, 1 = EXT
    logic             last_r;    // master granted by the most recent acceptance
    logic [CNT_W-1:0] cnt_r;

    logic cpu_req_s;
    logic ext_req_s;
    logic gnt_s;
    logic gnt_vld_s;
    logic sel_load_s;
    logic sel_store_s;
    logic accept_s;
    logic timeout_s;
    logic done_s;

    assign cpu_req_s = cpu_load_i | cpu_store_i;
    assign ext_req_s = ext_load_i | ext_store_i;

    // Grant selection: round-robin on ties in IDLE, locked to the owner in HOLD.
    always_comb begin
        gnt_s     = 1'b0;
        gnt_vld_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cpu_req_s && ext_req_s) begin
                    gnt_s     = ~last_r;
                    gnt_vld_s = 1'b1;
                end else if (cpu_req_s) begin
                    gnt_s     = 1'b0;
                    gnt_vld_s = 1'b1;
                end else if (ext_req_s) begin
                    gnt_s     = 1'b1;
                    gnt_vld_s = 1'b1;
                end else begin
                    gnt_s     = 1'b0;
                    gnt_vld_s = 1'b0;
                end
            end
            ST_HOLD: begin
                gnt_s     = owner_r;
                gnt_vld_s = owner_r ? ext_req_s : cpu_req_s;
            end
            ST_WAIT: begin
                gnt_s     = owner_r;
                gnt_vld_s = 1'b0;
            end
            default: begin
                gnt_s     = 1'b0;
                gnt_vld_s = 1'b0;
            end
        endcase
    end

    // Request path mux: the granted master's fields drive the memory port.
    always_comb begin
        if (gnt_s) begin
            dm_addr_o        = ext_addr_i;
            dm_data_s_o      = ext_data_s_i;
            dm_data_select_o = ext_data_select_i;
            sel_load_s       = ext_load_i;
            sel_store_s      = ext_store_i;
        end else begin
            dm_addr_o        = cpu_addr_i;
            dm_data_s_o      = cpu_data_s_i;
            dm_data_select_o = cpu_data_select_i;
            sel_load_s       = cpu_load_i;
            sel_store_s      = cpu_store_i;
        end
    end

    // Load wins over a simultaneous store; all handshakes are held low in reset.
    assign dm_load_o   = rst_n_i & gnt_vld_s & sel_load_s;
    assign dm_store_o  = rst_n_i & gnt_vld_s & sel_store_s & ~sel_load_s;
    assign accept_s    = gnt_vld_s & dm_ready_i;
    assign cpu_ready_o = rst_n_i & accept_s & ~gnt_s;
    assign ext_ready_o = rst_n_i & accept_s & gnt_s;

    // Completion path: real done or forced timeout completion, to the owner only.
    assign timeout_s       = (state_r == ST_WAIT) & ~dm_load_done_i & (cnt_r == CNT_LAST);
    assign done_s          = rst_n_i & (state_r == ST_WAIT) & (dm_load_done_i | timeout_s);
    assign cpu_load_done_o = done_s & ~owner_r;
    assign ext_load_done_o = done_s & owner_r;
    assign cpu_data_l_o    = timeout_s ? 32'h0000_0000 : dm_data_l_i;
    assign ext_data_l_o    = timeout_s ? 32'h0000_0000 : dm_data_l_i;

    // Arbitration state machine, timeout counter and registered error pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r       <= ST_IDLE;
            owner_r       <= 1'b0;
            last_r        <= 1'b1;
            cnt_r         <= {CNT_W{1'b0}};
            err_timeout_o <= 1'b0;
        end else begin
            err_timeout_o <= 1'b0;
            case (state_r)
                ST_IDLE, ST_HOLD: begin
                    if (accept_s) begin
                        last_r  <= gnt_s;
                        owner_r <= gnt_s;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= sel_load_s ? ST_WAIT : ST_IDLE;
                    end else if (gnt_vld_s) begin
                        owner_r <= gnt_s;
                        state_r <= ST_HOLD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (dm_load_done_i) begin
                        state_r <= ST_IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r       <= ST_IDLE;
                        err_timeout_o <= 1'b1;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    rv_dm_arbiter_chk u_chk (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .cpu_load_i  (cpu_load_i),
        .cpu_store_i (cpu_store_i),
        .ext_load_i  (ext_load_i),
        .ext_store_i (ext_store_i)
    );

endmodule

// Protocol checker: a master must never raise load and store together.
module rv_dm_arbiter_chk (
    input logic clk_i,
    input logic rst_n_i,
    input logic cpu_load_i,
    input logic cpu_store_i,
    input logic ext_load_i,
    input logic ext_store_i
);

    a_cpu_ld_st_excl: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(cpu_load_i && cpu_store_i));
    a_ext_ld_st_excl: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(ext_load_i && ext_store_i));

endmodule
